// File: rtl/bitfusion_column_sys_if.sv
// Handshake bundle between the activation/weight buffers, the column and the output buffer.
// The master drives weights and tagged input vectors; the slave returns group results.
interface bitfusion_column_sys_if #(
    parameter int NUM_ROWS = 16,
    parameter int DATA_W   = 32,
    parameter int ACC_W    = 32
);
    localparam int ROW_W = $clog2(NUM_ROWS);

    logic                       w_we;
    logic [ROW_W-1:0]           w_row;
    logic [DATA_W-1:0]          w_data;
    logic                       in_valid;
    logic [NUM_ROWS*DATA_W-1:0] in_data;
    logic [1:0]                 in_mode;
    logic                       in_sign_x;
    logic                       in_sign_y;
    logic                       in_last;
    logic                       acc_clear;
    logic                       out_valid;
    logic [ACC_W-1:0]           out_data;
    logic                       busy;

    modport master (
        output w_we, w_row, w_data, in_valid, in_data, in_mode,
               in_sign_x, in_sign_y, in_last, acc_clear,
        input  out_valid, out_data, busy
    );

    modport slave (
        input  w_we, w_row, w_data, in_valid, in_data, in_mode,
               in_sign_x, in_sign_y, in_last, acc_clear,
        output out_valid, out_data, busy
    );
endinterface

// File: rtl/bitfusion_column_sys.sv
// One systolic column of runtime-precision (8/4/2-bit) dot-product rows.
// The rows feed a partial-sum chain that ends in a group accumulator at the column foot.
module bitfusion_column_sys #(
    parameter int NUM_ROWS = 16,
    parameter int DATA_W   = 32,
    parameter int PSUM_W   = 24,
    parameter int ACC_W    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    bitfusion_column_sys_if.slave bus
);
    localparam logic [1:0] MODE_4B = 2'd1;
    localparam logic [1:0] MODE_2B = 2'd2;

    // Every lane width is evaluated and the vector's tag selects one.
    // Operands are widened to PSUM_W, so the chain wraps modulo 2^PSUM_W.
    function automatic logic [PSUM_W-1:0] lane_dot(
        input logic [DATA_W-1:0] x,
        input logic [DATA_W-1:0] w,
        input logic [1:0]        mode,
        input logic              sx,
        input logic              sy
    );
        logic signed [PSUM_W-1:0] s8, s4, s2, xa, wa;
        s8 = '0;
        s4 = '0;
        s2 = '0;
        for (int i = 0; i < DATA_W / 8; i++) begin
            xa = PSUM_W'($signed({sx & x[i*8+7], x[i*8 +: 8]}));
            wa = PSUM_W'($signed({sy & w[i*8+7], w[i*8 +: 8]}));
            s8 = s8 + xa * wa;
        end
        for (int i = 0; i < DATA_W / 4; i++) begin
            xa = PSUM_W'($signed({sx & x[i*4+3], x[i*4 +: 4]}));
            wa = PSUM_W'($signed({sy & w[i*4+3], w[i*4 +: 4]}));
            s4 = s4 + xa * wa;
        end
        for (int i = 0; i < DATA_W / 2; i++) begin
            xa = PSUM_W'($signed({sx & x[i*2+1], x[i*2 +: 2]}));
            wa = PSUM_W'($signed({sy & w[i*2+1], w[i*2 +: 2]}));
            s2 = s2 + xa * wa;
        end
        case (mode)
            MODE_4B: return s4;
            MODE_2B: return s2;
            default: return s8;
        endcase
    endfunction

    logic [DATA_W-1:0]                w_q [NUM_ROWS];
    logic [NUM_ROWS-1:0][PSUM_W-1:0]  dot_c;
    logic [PSUM_W-1:0]                psum_q [NUM_ROWS];
    logic [NUM_ROWS-1:0]              valid_q;
    logic [NUM_ROWS-1:0]              last_q;
    logic [1:0]                       mode_q [NUM_ROWS-1];
    logic [NUM_ROWS-2:0]              sign_x_q;
    logic [NUM_ROWS-2:0]              sign_y_q;

    logic             acc_vld_q;
    logic             group_open_q, group_open_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic             busy_c;
    logic             w_wr_c;

    assign busy_c = (|valid_q) | acc_vld_q;
    // Weights only change while the column is idle, so every in-flight vector sees one weight set.
    assign w_wr_c = bus.w_we & ~busy_c & ~bus.in_valid;

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        if (r == 0) begin : g_head
            assign dot_c[r] = lane_dot(bus.in_data[0 +: DATA_W], w_q[r],
                                       bus.in_mode, bus.in_sign_x, bus.in_sign_y);
        end else begin : g_body
            // Row r sees its activation word r cycles late, aligned with the vector's partial sum.
            logic [DATA_W-1:0] skew_q [r];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < r; k++) skew_q[k] <= '0;
                end else begin
                    skew_q[0] <= bus.in_data[r*DATA_W +: DATA_W];
                    for (int k = 1; k < r; k++) skew_q[k] <= skew_q[k-1];
                end
            end

            assign dot_c[r] = lane_dot(skew_q[r-1], w_q[r], mode_q[r-1],
                                       sign_x_q[r-1], sign_y_q[r-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: weights are architectural state; every word is cleared so that a reset
            // column computes zero instead of whatever the storage powered up with.
            for (int r = 0; r < NUM_ROWS; r++) begin
                w_q[r]    <= '0;
                psum_q[r] <= '0;
            end
            for (int r = 0; r < NUM_ROWS - 1; r++) mode_q[r] <= '0;
            valid_q  <= '0;
            last_q   <= '0;
            sign_x_q <= '0;
            sign_y_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage read its neighbour's old value,
            // which is what makes the loop below a shift rather than a ripple.
            if (w_wr_c) w_q[bus.w_row] <= bus.w_data;
            valid_q[0]  <= bus.in_valid;
            last_q[0]   <= bus.in_last;
            mode_q[0]   <= bus.in_mode;
            sign_x_q[0] <= bus.in_sign_x;
            sign_y_q[0] <= bus.in_sign_y;
            psum_q[0]   <= dot_c[0];
            for (int r = 1; r < NUM_ROWS; r++) begin
                valid_q[r] <= valid_q[r-1];
                last_q[r]  <= last_q[r-1];
                psum_q[r]  <= psum_q[r-1] + dot_c[r];
            end
            for (int r = 1; r < NUM_ROWS - 1; r++) begin
                mode_q[r]   <= mode_q[r-1];
                sign_x_q[r] <= sign_x_q[r-1];
                sign_y_q[r] <= sign_y_q[r-1];
            end
        end
    end

    // A clear in the same cycle as a foot partial closes the old group first,
    // so that partial opens the new one.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        acc_d        = acc_q;
        group_open_d = group_open_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        if (bus.acc_clear) begin
            acc_d        = '0;
            group_open_d = 1'b0;
        end
        if (valid_q[NUM_ROWS-1]) begin
            acc_d = (group_open_d ? acc_d : '0) + ACC_W'($signed(psum_q[NUM_ROWS-1]));
            if (last_q[NUM_ROWS-1]) begin
                out_valid_d  = 1'b1;
                out_data_d   = acc_d;
                group_open_d = 1'b0;
            end else begin
                group_open_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q        <= '0;
            group_open_q <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            acc_vld_q    <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            group_open_q <= group_open_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            acc_vld_q    <= valid_q[NUM_ROWS-1];
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_c;
endmodule

// File: tb/tb_bitfusion_column_sys.sv
// Self-checking bench for bitfusion_column_sys: directed vector table, group/clear/reset
// sequences, and a randomized run against a transaction-level reference model.
module tb_bitfusion_column_sys;
    localparam int NUM_ROWS = 16;
    localparam int DATA_W   = 32;
    localparam int PSUM_W   = 24;
    localparam int ACC_W    = 32;
    localparam int ROW_W    = $clog2(NUM_ROWS);
    localparam int LAT      = NUM_ROWS + 1;
    localparam int NC       = 200;
    localparam int NTBL     = 8;

    typedef struct {
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] x;
        logic [1:0]        mode;
        logic              sx;
        logic              sy;
        logic [ACC_W-1:0]  exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bitfusion_column_sys_if #(.NUM_ROWS(NUM_ROWS), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    bitfusion_column_sys #(
        .NUM_ROWS(NUM_ROWS), .DATA_W(DATA_W), .PSUM_W(PSUM_W), .ACC_W(ACC_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0]          w_model [NUM_ROWS];
    logic [ACC_W-1:0]           exp_hold;
    vec_t                       tbl [NTBL];

    logic                       r_v   [NC];
    logic [NUM_ROWS*DATA_W-1:0] r_x   [NC];
    logic [1:0]                 r_md  [NC];
    logic                       r_sx  [NC];
    logic                       r_sy  [NC];
    logic                       r_l   [NC];
    logic                       r_clr [NC];
    logic [ACC_W-1:0]           r_p   [NC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.w_we      = 1'b0;
        bus.w_row     = '0;
        bus.w_data    = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 2'd0;
        bus.in_sign_x = 1'b0;
        bus.in_sign_y = 1'b0;
        bus.in_last   = 1'b0;
        bus.acc_clear = 1'b0;
    endtask

    // Lane i of a word, b bits wide, read as signed or unsigned.
    function automatic int lane_val(input logic [DATA_W-1:0] word, input int i, input int b, input bit s);
        int v;
        v = 0;
        for (int k = 0; k < b; k++) if (word[i*b+k]) v += (1 << k);
        if (s && v >= (1 << (b - 1))) v -= (1 << b);
        return v;
    endfunction

    // Column partial: sum over rows and lanes, wrapped to PSUM_W, widened to ACC_W.
    function automatic logic [ACC_W-1:0] ref_partial(input logic [NUM_ROWS*DATA_W-1:0] xa,
                                                     input logic [1:0] mode, input bit sx, input bit sy);
        longint            sum;
        logic [PSUM_W-1:0] p;
        int                b;
        b   = (mode == 2'd1) ? 4 : (mode == 2'd2) ? 2 : 8;
        sum = 0;
        for (int r = 0; r < NUM_ROWS; r++)
            for (int i = 0; i < DATA_W / b; i++)
                sum += lane_val(xa[r*DATA_W +: DATA_W], i, b, sx) * lane_val(w_model[r], i, b, sy);
        p = sum[PSUM_W-1:0];
        return ACC_W'($signed(p));
    endfunction

    task automatic write_w(input int row, input logic [DATA_W-1:0] data);
        bus.w_we   = 1'b1;
        bus.w_row  = ROW_W'(row);
        bus.w_data = data;
        tick();
        bus.w_we   = 1'b0;
        w_model[row] = data;
    endtask

    task automatic write_all(input logic [DATA_W-1:0] data);
        for (int r = 0; r < NUM_ROWS; r++) write_w(r, data);
    endtask

    // One closing vector; returns cycles until the pulse, the result, and busy at cycle 1.
    task automatic send_one(input logic [NUM_ROWS*DATA_W-1:0] xa, input logic [1:0] mode,
                            input logic sx, input logic sy,
                            output int lat, output logic [ACC_W-1:0] data, output logic busy1);
        bus.in_valid  = 1'b1;
        bus.in_data   = xa;
        bus.in_mode   = mode;
        bus.in_sign_x = sx;
        bus.in_sign_y = sy;
        bus.in_last   = 1'b1;
        tick();
        idle_inputs();
        busy1 = bus.busy;
        lat   = 1;
        while (!bus.out_valid && lat < 60) begin
            tick();
            lat++;
        end
        data = bus.out_data;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int               lat;
        logic [ACC_W-1:0] data;
        logic             b1;
        write_all(v.w);
        send_one({NUM_ROWS{v.x}}, v.mode, v.sx, v.sy, lat, data, b1);
        check($sformatf("tbl%0d_latency", idx), lat, LAT);
        check($sformatf("tbl%0d_data", idx), data, v.exp);
        check($sformatf("tbl%0d_busy_c1", idx), b1, 1'b1);
        check($sformatf("tbl%0d_busy_pulse", idx), bus.busy, 1'b1);
        tick();
        check($sformatf("tbl%0d_busy_after", idx), bus.busy, 1'b0);
        check($sformatf("tbl%0d_valid_after", idx), bus.out_valid, 1'b0);
        exp_hold = v.exp;
    endtask

    // Three vectors at cycles 0..2, last on the third; optional clear at cycle 18.
    // Weight writes at cycle 0 (with in_valid) and cycle 5 (busy) must both be dropped.
    task automatic run_group(input bit with_clear, output int npulse, output int pcyc,
                             output logic [ACC_W-1:0] pdata);
        npulse = 0;
        pcyc   = -1;
        pdata  = '0;
        for (int c = 0; c < 26; c++) begin
            bus.in_valid  = (c < 3);
            bus.in_data   = {NUM_ROWS{32'h0202_0202}};
            bus.in_mode   = 2'd0;
            bus.in_sign_x = 1'b1;
            bus.in_sign_y = 1'b1;
            bus.in_last   = (c == 2);
            bus.w_we      = (c == 0) || (with_clear && c == 5);
            bus.w_row     = (c == 0) ? ROW_W'(3) : ROW_W'(0);
            bus.w_data    = '0;
            bus.acc_clear = with_clear && (c == 18);
            tick();
            if (bus.out_valid) begin
                npulse++;
                pcyc  = c + 1;
                pdata = bus.out_data;
            end
        end
        idle_inputs();
    endtask

    initial begin
        int               lat, np, pc, j;
        logic [ACC_W-1:0] data;
        logic             b1, ov, eb, open;
        logic [ACC_W-1:0] acc;

        tbl[0] = '{32'h0101_0101, 32'h0202_0202, 2'd0, 1'b1, 1'b1, 32'd128};
        tbl[1] = '{32'hFFFF_FFFF, 32'h7F7F_7F7F, 2'd0, 1'b1, 1'b1, 32'hFFFF_E040};
        tbl[2] = '{32'hFFFF_FFFF, 32'h7F7F_7F7F, 2'd0, 1'b0, 1'b0, 32'd2072640};
        tbl[3] = '{32'hFFFF_FFFF, 32'h5555_5555, 2'd2, 1'b0, 1'b0, 32'd768};
        tbl[4] = '{32'h1111_1111, 32'hFFFF_FFFF, 2'd1, 1'b1, 1'b1, 32'hFFFF_FF80};
        tbl[5] = '{32'h0101_0101, 32'h0202_0202, 2'd3, 1'b1, 1'b1, 32'd128};
        tbl[6] = '{32'h1111_1111, 32'hFFFF_FFFF, 2'd1, 1'b0, 1'b0, 32'd1920};
        tbl[7] = '{32'hFFFF_FFFF, 32'h8080_8080, 2'd0, 1'b1, 1'b0, 32'hFFE0_2000};

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_out_data", bus.out_data, 32'd0);
        check("reset_busy", bus.busy, 1'b0);

        for (int i = 0; i < NTBL; i++) run_vec(i, tbl[i]);

        write_all(32'h0101_0101);
        run_group(1'b0, np, pc, data);
        check("group_pulses", np, 1);
        check("group_cycle", pc, 19);
        check("group_data", data, 32'd384);
        run_group(1'b1, np, pc, data);
        check("clear_pulses", np, 1);
        check("clear_cycle", pc, 19);
        check("clear_data", data, 32'd128);
        send_one({NUM_ROWS{32'h0202_0202}}, 2'd0, 1'b1, 1'b1, lat, data, b1);
        check("weights_kept_latency", lat, LAT);
        check("weights_kept_data", data, 32'd128);
        tick();

        // Reset for two cycles while five closing vectors are in flight.
        for (int c = 0; c < 7; c++) begin
            bus.in_valid  = (c < 5);
            bus.in_data   = {NUM_ROWS{32'h0202_0202}};
            bus.in_sign_x = 1'b1;
            bus.in_sign_y = 1'b1;
            bus.in_last   = 1'b1;
            reset         = (c >= 5);
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        check("midreset_out_valid", bus.out_valid, 1'b0);
        check("midreset_out_data", bus.out_data, 32'd0);
        check("midreset_busy", bus.busy, 1'b0);
        np = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.out_valid) np++;
        end
        check("midreset_no_output", np, 0);
        for (int r = 0; r < NUM_ROWS; r++) w_model[r] = '0;
        send_one({NUM_ROWS{32'h0202_0202}}, 2'd0, 1'b1, 1'b1, lat, data, b1);
        check("post_reset_latency", lat, LAT);
        check("post_reset_weights_zero", data, 32'd0);
        tick();
        exp_hold = '0;

        // Randomized stream against the transaction-level model.
        for (int r = 0; r < NUM_ROWS; r++) write_w(r, $urandom);
        for (int k = 0; k < NC; k++) begin
            r_v[k]   = ($urandom_range(3) != 0);
            for (int r = 0; r < NUM_ROWS; r++) r_x[k][r*DATA_W +: DATA_W] = $urandom;
            r_md[k]  = 2'($urandom_range(3));
            r_sx[k]  = 1'($urandom_range(1));
            r_sy[k]  = 1'($urandom_range(1));
            r_l[k]   = ($urandom_range(3) == 0);
            r_clr[k] = ($urandom_range(19) == 0);
            r_p[k]   = ref_partial(r_x[k], r_md[k], r_sx[k], r_sy[k]);
        end
        acc  = '0;
        open = 1'b0;
        for (int k = 0; k < NC + NUM_ROWS + 3; k++) begin
            if (k < NC) begin
                bus.in_valid  = r_v[k];
                bus.in_data   = r_x[k];
                bus.in_mode   = r_md[k];
                bus.in_sign_x = r_sx[k];
                bus.in_sign_y = r_sy[k];
                bus.in_last   = r_l[k];
                bus.acc_clear = r_clr[k];
            end else begin
                idle_inputs();
            end
            tick();
            if (k < NC && r_clr[k]) begin
                acc  = '0;
                open = 1'b0;
            end
            ov = 1'b0;
            j  = k - NUM_ROWS;
            if (j >= 0 && j < NC && r_v[j]) begin
                acc = (open ? acc : '0) + r_p[j];
                if (r_l[j]) begin
                    ov       = 1'b1;
                    exp_hold = acc;
                    open     = 1'b0;
                end else begin
                    open = 1'b1;
                end
            end
            eb = 1'b0;
            for (int q = k - NUM_ROWS; q <= k; q++) if (q >= 0 && q < NC && r_v[q]) eb = 1'b1;
            check($sformatf("rnd_valid_c%0d", k + 1), bus.out_valid, ov);
            check($sformatf("rnd_data_c%0d", k + 1), bus.out_data, exp_hold);
            check($sformatf("rnd_busy_c%0d", k + 1), bus.busy, eb);
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bitfusion_column_sys.md
Name: bitfusion_column_sys

Overview:
- Parametrised successor of the fixed 16-row fused-PE column: NUM_ROWS rows of runtime-precision (8/4/2-bit) dot-product units, chained into a systolic partial-sum path.
- Has internal input skew, per-row weight registers, per-vector mode and sign tagging, and a single group accumulator at the column foot with last-flag output and clear.
- Sits between the activation/weight buffers and the output buffer; one instance per array column.

Parameters:
- NUM_ROWS, 16, rows in the column (>=2).
- DATA_W, 32, bits per row word; a multiple of 8.
- PSUM_W, 24, partial-sum width on the row chain. Products are sign-extended to this width; the chain wraps modulo 2^PSUM_W.
- ACC_W, 32, accumulator width. The partial sum is sign-extended to this width; accumulation wraps modulo 2^ACC_W.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- w_we  in  1  weight write strobe.
- w_row  in  $clog2(NUM_ROWS)  target row for the weight write.
- w_data  in  DATA_W  weight word.
- in_valid  in  1  input vector valid.
- in_data  in  NUM_ROWS*DATA_W  activation words; row r is bits [r*DATA_W +: DATA_W].
- in_mode  in  2  lane width: 0=8b, 1=4b, 2=2b, 3=treated as 8b.
- in_sign_x  in  1  activations are signed (1) or unsigned (0).
- in_sign_y  in  1  weights are signed (1) or unsigned (0).
- in_last  in  1  vector closes the accumulation group.
- acc_clear  in  1  discard the current group sum.
- out_valid  out  1  one-cycle pulse; group result valid.
- out_data  out  ACC_W  group result.
- busy  out  1  any vector is in flight.

Behaviour:
- Reset is synchronous:
  - clears all weights, skew and chain registers, and valid/tag bits;
  - clears the accumulator and out_data to 0;
  - sets out_valid=0 and busy=0;
  - aborts in-flight vectors with no output.
- Lanes: b = 8, 4 or 2 bits per lane, giving DATA_W/b lanes per row.
  - Lane i is bits [i*b +: b] of both the activation word and the weight word.
  - Each operand is interpreted per its sign flag.
  - Row dot = sum over lanes of x_i*w_i.
- Vector tagging:
  - mode, signs and last are sampled together with in_valid.
  - Tags travel with the vector, so mode may change every cycle without corrupting in-flight vectors.
- Input skew: row r uses its activation word delayed r cycles, so the whole vector is presented in one cycle.
- Chain: a vector accepted at cycle t leaves row r's registered output at t+r+1.
  - Row 0 output = dot_0.
  - Row r output = row r-1 output + dot_r.
  - The foot partial is available at t+NUM_ROWS.
- Throughput: one vector per cycle with no bubbles. There is no backpressure; the source must not expect stalls.
- Accumulator: when a foot partial arrives, acc <= (group_open ? acc : 0) + partial.
  - If the vector carried in_last, then at t+NUM_ROWS+1: out_valid=1, out_data=the new sum, and the group closes (next partial starts from 0).
  - Otherwise out_data holds its last value.
- acc_clear:
  - Zeros the accumulator and closes the group.
  - Does not flush the chain.
  - If asserted in the same cycle a partial arrives, the clear takes effect first; that partial starts the new group (acc = partial).
- Weights:
  - A write with w_we=1 and busy=0 takes effect the next cycle.
  - A write with w_we=1 while busy=1 is ignored.
  - A write in the same cycle as in_valid with busy=0 is applied after that vector is tagged busy; it is ignored.
- busy = OR of all chain valid bits plus the accumulator-stage valid bit. It is high from t+1 through the cycle out_valid/final partial is registered.

Test Plan:
- Reset: assert reset for 2 cycles mid-stream -> out_valid=0, out_data=0, busy=0, and no later output from aborted vectors.
- 8b signed, all weights 0x01010101, all rows 0x02020202, in_last=1 at cycle 0 -> out_valid at cycle 17 with out_data=128; busy low from cycle 18.
- 8b signed, weights 0xFFFFFFFF, activations 0x7F7F7F7F -> out_data=0xFFFFE040 (-8128). Same vector with both sign flags 0 -> 2072640.
- 2b unsigned, weights 0xFFFFFFFF, activations 0x55555555 -> 768.
- 4b signed, weights 0x11111111, activations 0xFFFFFFFF -> -128 (0xFFFFFF80).
- Group and clear: test-2 vector at cycles 0,1,2 with last only at cycle 2 -> single pulse at cycle 19 with 384.
  - Repeat, with acc_clear at cycle 18 -> pulse value 128.
  - w_we at cycle 5 -> weights unchanged.
